axil_selftest_master: RTL and testbench
=======================================

AXIL_SELFTEST_MASTER -- requirements
Module: axil_selftest_master
Interface
REQ-001 C_M_AXI_ADDR_WIDTH, 4, AXI4-Lite address width; data width fixed at 32.
REQ-002 C_BASE_ADDR, 0, byte address of the first slave register.
REQ-003 C_NUM_REGS, 4, number of consecutive 32-bit registers tested (1..16).
REQ-004 C_START_DATA, 32'h00000001, pattern for register 0; register k receives C_START_DATA+k.
REQ-005 ACLK  in  1  single clock; all logic on rising edge.
REQ-006 ARESETN  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle pulse; ignored unless FSM is IDLE.
REQ-008 done  out  1  one-cycle pulse when the test sequence completes.
REQ-009 fail  out  1  sticky; set on any mismatch or non-OKAY response; cleared by the next accepted start.
REQ-010 M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  write address.
REQ-011 M_AXI_AWPROT  out  3  constant 3'b000.
REQ-012 M_AXI_AWVALID  out  1  write address valid.
REQ-013 M_AXI_AWREADY  in  1  write address ready.
REQ-014 M_AXI_WDATA  out  32  write data.
REQ-015 M_AXI_WSTRB  out  4  constant 4'hF.
REQ-016 M_AXI_WVALID  out  1  write data valid.
REQ-017 M_AXI_WREADY  in  1  write data ready.
REQ-018 M_AXI_BRESP  in  2  write response.
REQ-019 M_AXI_BVALID  in  1  write response valid.
REQ-020 M_AXI_BREADY  out  1  write response ready.
REQ-021 M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  read address.
REQ-022 M_AXI_ARPROT  out  3  constant 3'b000.
REQ-023 M_AXI_ARVALID  out  1  read address valid.
REQ-024 M_AXI_ARREADY  in  1  read address ready.
REQ-025 M_AXI_RDATA  in  32  read data.
REQ-026 M_AXI_RRESP  in  2  read response.
REQ-027 M_AXI_RVALID  in  1  read data valid.
REQ-028 M_AXI_RREADY  out  1  read data ready.
Function
REQ-029 FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH; register index idx counts 0..C_NUM_REGS-1.
REQ-030 IDLE + start: fail<=0, idx<=0, go to WR_REQ the next cycle.
REQ-031 WR_REQ: AWVALID and WVALID assert together (AWADDR=C_BASE_ADDR+4*idx, WDATA=C_START_DATA+idx); each drops independently on its own VALID&READY; go to WR_RESP once both channels have handshaken, including same-cycle handshakes.
REQ-032 WR_RESP: BREADY=1; on BVALID, BRESP!=OKAY sets fail; last idx -> RD_REQ with idx<=0, else idx+1 -> WR_REQ.
REQ-033 RD_REQ: ARVALID=1, ARADDR=C_BASE_ADDR+4*idx; on ARREADY go to RD_RESP.
REQ-034 RD_RESP: RREADY=1; on RVALID, RDATA!=C_START_DATA+idx or RRESP!=OKAY sets fail; last idx -> FINISH, else idx+1 -> RD_REQ.
REQ-035 FINISH: done=1 for exactly one cycle, then IDLE; fail holds its value.
REQ-036 At most one outstanding transaction; VALID never deasserts before its handshake; address/data stable while VALID.
REQ-037 Pattern addition wraps modulo 2^32; address addition wraps modulo 2^C_M_AXI_ADDR_WIDTH.
REQ-038 No timeout: a stalled slave holds the FSM in the current state indefinitely.
Reset
REQ-039 ARESETN=0 at a rising edge: state=IDLE, idx=0, all VALID/READY outputs=0, done=0, fail=0, even mid-transaction.
REQ-040 Reset holds outputs at their reset values while low; after release, start is honoured on the first cycle.
Structure
REQ-041 Package axil_selftest_pkg holds the FSM state enum and the AXI response codes (OKAY=2'b00).
REQ-042 Single module, no sub-modules; output registers only, no combinational input-to-output paths.
Verification
REQ-043 Defaults, zero-wait slave with 4 registers: start -> writes 1,2,3,4 to 0x0,0x4,0x8,0xC, reads back identical data, done pulses, fail=0.
REQ-044 Slave drives AWREADY 3 cycles before WREADY -> one AW and one W handshake per write, no duplicates, same final result.
REQ-045 Register 2 returns 0xDEADBEEF -> all 4 reads still issued, done pulses, fail=1.
REQ-046 BRESP=SLVERR on write 1 -> sequence completes, fail=1; next start with a clean slave -> fail cleared, done, fail=0.
REQ-047 ARESETN low during RD_RESP of idx 1 -> next edge all VALIDs=0, state IDLE; start after release -> full pass.
REQ-048 C_START_DATA=32'hFFFFFFFF, C_NUM_REGS=2 -> writes 0xFFFFFFFF then 0x00000000; start pulsed while busy is ignored.

Source files
------------

// File: rtl/axil_selftest_pkg.sv
// Shared types and constants for the AXI4-Lite self-test master.
// Contents: FSM state encoding and AXI response codes.
package axil_selftest_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrReq  = 3'd1,
    StWrResp = 3'd2,
    StRdReq  = 3'd3,
    StRdResp = 3'd4,
    StFinish = 3'd5
  } state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExokay = 2'b01;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

endpackage

// File: rtl/axil_selftest_master_if.sv
// AXI4-Lite bus bundle (32-bit data) between the self-test master and a slave.
// Modports:
//   master - drives AW/W/AR channels and B/R ready, samples the rest
//   slave  - the mirror image
interface axil_selftest_master_if #(
  parameter int unsigned AddrWidth = 4
);

  logic [AddrWidth-1:0] M_AXI_AWADDR;
  logic [2:0]           M_AXI_AWPROT;
  logic                 M_AXI_AWVALID;
  logic                 M_AXI_AWREADY;
  logic [31:0]          M_AXI_WDATA;
  logic [3:0]           M_AXI_WSTRB;
  logic                 M_AXI_WVALID;
  logic                 M_AXI_WREADY;
  logic [1:0]           M_AXI_BRESP;
  logic                 M_AXI_BVALID;
  logic                 M_AXI_BREADY;
  logic [AddrWidth-1:0] M_AXI_ARADDR;
  logic [2:0]           M_AXI_ARPROT;
  logic                 M_AXI_ARVALID;
  logic                 M_AXI_ARREADY;
  logic [31:0]          M_AXI_RDATA;
  logic [1:0]           M_AXI_RRESP;
  logic                 M_AXI_RVALID;
  logic                 M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );

endinterface

// File: rtl/axil_selftest_master.sv
// AXI4-Lite self-test master. On start, writes C_START_DATA+k to register k
// (k = 0..C_NUM_REGS-1, byte address C_BASE_ADDR+4k), then reads every register
// back and compares. One transaction outstanding at a time; all bus outputs are
// registered.
// Ports:
//   ACLK, ARESETN - clock, synchronous active-low reset
//   start         - one-cycle request, honoured only when idle
//   done          - one-cycle pulse at the end of the sequence
//   fail          - sticky error flag (data mismatch or non-OKAY response),
//                   cleared by the next accepted start
//   m_axi         - AXI4-Lite master port
module axil_selftest_master
  import axil_selftest_pkg::*;
#(
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
  parameter int unsigned                   C_NUM_REGS         = 4,
  parameter logic [31:0]                   C_START_DATA       = 32'h0000_0001
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          start,
  output logic                          done,
  output logic                          fail,
  axil_selftest_master_if.master        m_axi
);

  localparam logic [2:0] SIdle   = StIdle;
  localparam logic [2:0] SWrReq  = StWrReq;
  localparam logic [2:0] SWrResp = StWrResp;
  localparam logic [2:0] SRdReq  = StRdReq;
  localparam logic [2:0] SRdResp = StRdResp;
  localparam logic [2:0] SFinish = StFinish;

  localparam logic [3:0] LastIdx = 4'(C_NUM_REGS - 1);

  // Both additions wrap naturally at their declared widths.
  function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] addr_of(input logic [3:0] idx);
    logic [C_M_AXI_ADDR_WIDTH+5:0] off;
    off = (C_M_AXI_ADDR_WIDTH+6)'({idx, 2'b00});
    return C_BASE_ADDR + off[C_M_AXI_ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [31:0] data_of(input logic [3:0] idx);
    return C_START_DATA + {28'd0, idx};
  endfunction

  logic [2:0]                    state_q, state_d;
  logic [3:0]                    idx_q, idx_d;
  logic                          awvalid_q, awvalid_d;
  logic                          wvalid_q, wvalid_d;
  logic                          bready_q, bready_d;
  logic                          arvalid_q, arvalid_d;
  logic                          rready_q, rready_d;
  logic                          done_q, done_d;
  logic                          fail_q, fail_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [31:0]                   wdata_q, wdata_d;

  logic       last;
  logic [3:0] idx_inc;
  logic       aw_pending, w_pending;

  assign last    = (idx_q == LastIdx);
  assign idx_inc = idx_q + 4'd1;

  // A channel is still pending only if its VALID is up and not accepted now.
  assign aw_pending = awvalid_q && !m_axi.M_AXI_AWREADY;
  assign w_pending  = wvalid_q && !m_axi.M_AXI_WREADY;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    done_d    = 1'b0;
    fail_d    = fail_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;

    case (state_q)
      SIdle: begin
        if (start) begin
          fail_d    = 1'b0;
          idx_d     = 4'd0;
          state_d   = SWrReq;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = addr_of(4'd0);
          wdata_d   = data_of(4'd0);
        end
      end
      SWrReq: begin
        if (awvalid_q && m_axi.M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!aw_pending && !w_pending) begin
          state_d  = SWrResp;
          bready_d = 1'b1;
        end
      end
      SWrResp: begin
        if (m_axi.M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (m_axi.M_AXI_BRESP != RespOkay) fail_d = 1'b1;
          if (last) begin
            idx_d     = 4'd0;
            state_d   = SRdReq;
            arvalid_d = 1'b1;
            araddr_d  = addr_of(4'd0);
          end else begin
            idx_d     = idx_inc;
            state_d   = SWrReq;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = addr_of(idx_inc);
            wdata_d   = data_of(idx_inc);
          end
        end
      end
      SRdReq: begin
        if (m_axi.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = SRdResp;
        end
      end
      SRdResp: begin
        if (m_axi.M_AXI_RVALID) begin
          rready_d = 1'b0;
          if ((m_axi.M_AXI_RDATA != data_of(idx_q)) || (m_axi.M_AXI_RRESP != RespOkay)) begin
            fail_d = 1'b1;
          end
          if (last) begin
            state_d = SFinish;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx_inc;
            state_d   = SRdReq;
            arvalid_d = 1'b1;
            araddr_d  = addr_of(idx_inc);
          end
        end
      end
      SFinish: state_d = SIdle;
      default: state_d = SIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= SIdle;
      idx_q     <= 4'd0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign done = done_q;
  assign fail = fail_q;

  assign m_axi.M_AXI_AWADDR  = awaddr_q;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = 4'hF;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARADDR  = araddr_q;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_selftest_master.sv
// Bench for axil_selftest_master: dut_a uses default parameters against a
// configurable slave model; dut_b uses C_START_DATA=FFFFFFFF, C_NUM_REGS=2.
module tb_axil_selftest_master;

  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, done_a, fail_a;
  logic start_b, done_b, fail_b;

  axil_selftest_master_if #(.AddrWidth(AW)) bus_a ();
  axil_selftest_master_if #(.AddrWidth(AW)) bus_b ();

  axil_selftest_master #(
    .C_M_AXI_ADDR_WIDTH(AW)
  ) dut_a (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .start   (start_a),
    .done    (done_a),
    .fail    (fail_a),
    .m_axi   (bus_a.master)
  );

  axil_selftest_master #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_BASE_ADDR       (4'h0),
    .C_NUM_REGS        (2),
    .C_START_DATA      (32'hFFFF_FFFF)
  ) dut_b (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .start   (start_b),
    .done    (done_b),
    .fail    (fail_b),
    .m_axi   (bus_b.master)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard for dut_a ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  wr_t           exp_wr_q[$];
  logic [AW-1:0] exp_rd_q[$];

  // Slave knobs (index -1 disables)
  int w_delay     = 0;
  int corrupt_idx = -1;
  int slverr_idx  = -1;
  int rstall_idx  = -1;

  logic [31:0]   mem_a [4];
  logic          aw_got, w_got, wready_r, bvalid_r, rvalid_r;
  logic [AW-1:0] aw_addr_r;
  logic [31:0]   w_data_r, rdata_r;
  logic [1:0]    bresp_r;
  int            wcnt, dup_cnt, rd_cnt, wr_cnt;

  assign bus_a.M_AXI_AWREADY = 1'b1;
  assign bus_a.M_AXI_WREADY  = (w_delay == 0) ? 1'b1 : wready_r;
  assign bus_a.M_AXI_ARREADY = 1'b1;
  assign bus_a.M_AXI_BVALID  = bvalid_r;
  assign bus_a.M_AXI_BRESP   = bresp_r;
  assign bus_a.M_AXI_RVALID  = rvalid_r;
  assign bus_a.M_AXI_RDATA   = rdata_r;
  assign bus_a.M_AXI_RRESP   = 2'b00;

  always @(posedge clk) begin : slave_a
    logic          aw_hs, w_hs;
    logic [AW-1:0] a;
    logic [31:0]   d;
    wr_t           e;
    int            ri;
    if (!rst_n) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      wready_r <= 1'b0;
      wcnt     <= 0;
      bvalid_r <= 1'b0;
      bresp_r  <= 2'b00;
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
    end else begin
      aw_hs = bus_a.M_AXI_AWVALID && bus_a.M_AXI_AWREADY;
      w_hs  = bus_a.M_AXI_WVALID && bus_a.M_AXI_WREADY;
      if ((aw_hs && (aw_got || bvalid_r)) || (w_hs && (w_got || bvalid_r))) dup_cnt <= dup_cnt + 1;
      if (w_delay != 0) begin
        if (w_hs) begin
          wready_r <= 1'b0;
          wcnt     <= 0;
        end else if (bus_a.M_AXI_WVALID && !wready_r) begin
          if (wcnt == w_delay - 1) wready_r <= 1'b1;
          wcnt <= wcnt + 1;
        end
      end
      a = aw_hs ? bus_a.M_AXI_AWADDR : aw_addr_r;
      d = w_hs ? bus_a.M_AXI_WDATA : w_data_r;
      if (aw_hs) begin aw_got <= 1'b1; aw_addr_r <= bus_a.M_AXI_AWADDR; end
      if (w_hs)  begin w_got <= 1'b1;  w_data_r <= bus_a.M_AXI_WDATA;   end
      if ((aw_got || aw_hs) && (w_got || w_hs) && !bvalid_r) begin
        mem_a[a[3:2]] <= d;
        wr_cnt   <= wr_cnt + 1;
        bvalid_r <= 1'b1;
        bresp_r  <= (int'(a[3:2]) == slverr_idx) ? 2'b10 : 2'b00;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
        check("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
        if (exp_wr_q.size() != 0) begin
          e = exp_wr_q.pop_front();
          check("wr_addr", 32'(a), 32'(e.addr));
          check("wr_data", d, e.data);
        end
      end
      if (bvalid_r && bus_a.M_AXI_BREADY) bvalid_r <= 1'b0;
      if (bus_a.M_AXI_ARVALID && bus_a.M_AXI_ARREADY) begin
        rd_cnt <= rd_cnt + 1;
        ri = int'(bus_a.M_AXI_ARADDR[3:2]);
        check("rd_expected", 32'(exp_rd_q.size() != 0), 32'd1);
        if (exp_rd_q.size() != 0) check("rd_addr", 32'(bus_a.M_AXI_ARADDR), 32'(exp_rd_q.pop_front()));
        if (ri != rstall_idx) begin
          rvalid_r <= 1'b1;
          rdata_r  <= (ri == corrupt_idx) ? 32'hDEAD_BEEF : mem_a[ri[1:0]];
        end
      end
      if (rvalid_r && bus_a.M_AXI_RREADY) rvalid_r <= 1'b0;
    end
  end

  // ---------------- zero-wait slave for dut_b ----------------
  logic [31:0]   mem_b [4];
  logic          bvalid_b, rvalid_b;
  logic [31:0]   rdata_b;
  logic [31:0]   obs_b_wdata[$];
  logic [AW-1:0] obs_b_waddr[$];

  assign bus_b.M_AXI_AWREADY = 1'b1;
  assign bus_b.M_AXI_WREADY  = 1'b1;
  assign bus_b.M_AXI_ARREADY = 1'b1;
  assign bus_b.M_AXI_BVALID  = bvalid_b;
  assign bus_b.M_AXI_BRESP   = 2'b00;
  assign bus_b.M_AXI_RVALID  = rvalid_b;
  assign bus_b.M_AXI_RDATA   = rdata_b;
  assign bus_b.M_AXI_RRESP   = 2'b00;

  always @(posedge clk) begin
    if (!rst_n) begin
      bvalid_b <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_b  <= '0;
    end else begin
      if (bus_b.M_AXI_AWVALID && bus_b.M_AXI_WVALID) begin
        mem_b[bus_b.M_AXI_AWADDR[3:2]] <= bus_b.M_AXI_WDATA;
        obs_b_wdata.push_back(bus_b.M_AXI_WDATA);
        obs_b_waddr.push_back(bus_b.M_AXI_AWADDR);
        bvalid_b <= 1'b1;
      end
      if (bvalid_b && bus_b.M_AXI_BREADY) bvalid_b <= 1'b0;
      if (bus_b.M_AXI_ARVALID) begin
        rvalid_b <= 1'b1;
        rdata_b  <= mem_b[bus_b.M_AXI_ARADDR[3:2]];
      end
      if (rvalid_b && bus_b.M_AXI_RREADY) rvalid_b <= 1'b0;
    end
  end

  int done_cnt_b = 0;
  always @(negedge clk) if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;

  // ---------------- helpers ----------------
  task automatic push_exp_a();
    wr_t e;
    for (int k = 0; k < 4; k++) begin
      e.addr = AW'(4 * k);
      e.data = 32'(k + 1);
      exp_wr_q.push_back(e);
      exp_rd_q.push_back(AW'(4 * k));
    end
  endtask

  // Called at a negedge with start already driven high.
  task automatic accept_a(input string tag);
    @(negedge clk);
    start_a = 1'b0;
    check({tag, "_fail_cleared"}, 32'(fail_a), 32'd0);
    check({tag, "_awvalid"}, 32'(bus_a.M_AXI_AWVALID), 32'd1);
  endtask

  task automatic finish_a(input string tag, input logic exp_fail);
    int n = 0;
    while (done_a !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done_a), 32'd1);
    check({tag, "_fail"}, 32'(fail_a), 32'(exp_fail));
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(done_a), 32'd0);
    check({tag, "_fail_hold"}, 32'(fail_a), 32'(exp_fail));
    check({tag, "_wr_q_empty"}, 32'(exp_wr_q.size()), 32'd0);
    check({tag, "_rd_q_empty"}, 32'(exp_rd_q.size()), 32'd0);
  endtask

  task automatic run_a(input string tag, input logic exp_fail);
    push_exp_a();
    start_a = 1'b1;
    accept_a(tag);
    finish_a(tag, exp_fail);
  endtask

  task automatic check_idle_outputs_a(input string tag);
    check({tag, "_awvalid"}, 32'(bus_a.M_AXI_AWVALID), 32'd0);
    check({tag, "_wvalid"},  32'(bus_a.M_AXI_WVALID),  32'd0);
    check({tag, "_bready"},  32'(bus_a.M_AXI_BREADY),  32'd0);
    check({tag, "_arvalid"}, 32'(bus_a.M_AXI_ARVALID), 32'd0);
    check({tag, "_rready"},  32'(bus_a.M_AXI_RREADY),  32'd0);
    check({tag, "_done"},    32'(done_a), 32'd0);
    check({tag, "_fail"},    32'(fail_a), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, n;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    dup_cnt = 0;
    rd_cnt  = 0;
    wr_cnt  = 0;
    for (int k = 0; k < 4; k++) begin
      mem_a[k] = '0;
      mem_b[k] = '0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    check_idle_outputs_a("reset");
    check("reset_awprot", 32'(bus_a.M_AXI_AWPROT), 32'd0);
    check("reset_arprot", 32'(bus_a.M_AXI_ARPROT), 32'd0);
    check("reset_wstrb", 32'(bus_a.M_AXI_WSTRB), 32'hF);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait pass
    run_a("basic", 1'b0);
    for (int k = 0; k < 4; k++) check("basic_mem", mem_a[k], 32'(k + 1));

    // AWREADY leads WREADY by 3 cycles
    for (int k = 0; k < 4; k++) mem_a[k] = '0;
    w_delay = 3;
    run_a("awlead", 1'b0);
    w_delay = 0;
    check("awlead_dups", 32'(dup_cnt), 32'd0);
    for (int k = 0; k < 4; k++) check("awlead_mem", mem_a[k], 32'(k + 1));

    // Register 2 reads back 0xDEADBEEF
    corrupt_idx = 2;
    rd0 = rd_cnt;
    run_a("corrupt", 1'b1);
    corrupt_idx = -1;
    check("corrupt_reads", 32'(rd_cnt - rd0), 32'd4);

    // SLVERR on write 1, then a clean rerun clears fail
    slverr_idx = 1;
    run_a("slverr", 1'b1);
    slverr_idx = -1;
    run_a("clean", 1'b0);

    // Reset during RD_RESP of idx 1 (read 0 already flagged a mismatch)
    corrupt_idx = 0;
    rstall_idx  = 1;
    rd0 = rd_cnt;
    push_exp_a();
    start_a = 1'b1;
    accept_a("midrst");
    n = 0;
    while (!((rd_cnt - rd0) == 2 && bus_a.M_AXI_RREADY === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("midrst_in_rdresp", 32'(bus_a.M_AXI_RREADY), 32'd1);
    check("midrst_fail_set", 32'(fail_a), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs_a("midrst");
    exp_wr_q.delete();
    exp_rd_q.delete();
    corrupt_idx = -1;
    rstall_idx  = -1;
    @(negedge clk);
    check_idle_outputs_a("midrst_hold");
    // start honoured on the first cycle after release
    push_exp_a();
    rst_n   = 1'b1;
    start_a = 1'b1;
    accept_a("postrst");
    finish_a("postrst", 1'b0);

    // dut_b: wrapping pattern, start while busy ignored
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (2) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (done_b !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wrap_done", 32'(done_b), 32'd1);
    repeat (10) @(negedge clk);
    check("wrap_done_count", 32'(done_cnt_b), 32'd1);
    check("wrap_fail", 32'(fail_b), 32'd0);
    check("wrap_writes", 32'(obs_b_wdata.size()), 32'd2);
    if (obs_b_wdata.size() >= 2) begin
      check("wrap_wdata0", obs_b_wdata[0], 32'hFFFF_FFFF);
      check("wrap_wdata1", obs_b_wdata[1], 32'h0000_0000);
      check("wrap_waddr0", 32'(obs_b_waddr[0]), 32'h0);
      check("wrap_waddr1", 32'(obs_b_waddr[1]), 32'h4);
    end
    check("wrap_idle_awvalid", 32'(bus_b.M_AXI_AWVALID), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
